// File: rtl/noc_output_arbiter_if.sv
// noc_output_arbiter_if
// Handshake bundle between one router output port and its arbiter.
//   req       : per-requester "flit valid for this output"
//   tail      : per-requester "presented flit is the packet tail"
//   out_ready : downstream can take a flit this cycle
//   grant     : registered one-hot grant (mux select / ready to winner)
//   grant_id  : binary index of the granted requester, 0 when idle
//   locked    : a packet currently owns the output
//   accept    : a flit transfers this cycle
// master = arbiter side, slave = requester/output side.
interface noc_output_arbiter_if #(
  parameter int PORTS = 5
);
  localparam int ID_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0] req;
  logic [PORTS-1:0] tail;
  logic             out_ready;
  logic [PORTS-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             locked;
  logic             accept;

  modport master (
    input  req, tail, out_ready,
    output grant, grant_id, locked, accept
  );

  modport slave (
    output req, tail, out_ready,
    input  grant, grant_id, locked, accept
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
// Packet-level round-robin arbiter for one router output port. Requesters
// 0..4 are x+, x-, y+, y-, local. The grant is taken on a packet's head
// flit and held until its tail flit transfers, so packets never interleave.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : noc_output_arbiter_if.master (req, tail, out_ready in;
//          grant, grant_id, locked, accept out)
// Parameters:
//   PORTS           : number of requesters
//   AVAILABLE_PORTS : requesters with a clear bit are never granted
module noc_output_arbiter #(
  parameter int               PORTS           = 5,
  parameter logic [PORTS-1:0] AVAILABLE_PORTS = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_output_arbiter_if.master bus
);

  localparam int              ID_W    = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [ID_W:0]   PORTS_W = (ID_W+1)'(PORTS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(PORTS - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [PORTS-1:0] eligible;
  logic             is_locked;
  logic             accept_w;
  logic             tail_accept;
  logic [ID_W-1:0]  next_ptr;
  logic [ID_W-1:0]  pick_idle;
  logic [ID_W-1:0]  pick_tail;

  // First eligible index searching upward from start, wrapping modulo PORTS.
  // Returns 0 when nothing is eligible; callers gate on |elig.
  function automatic logic [ID_W-1:0] rr_pick(input logic [PORTS-1:0] elig,
                                              input logic [ID_W-1:0]  start);
    logic [ID_W-1:0] pick;
    logic            found;
    logic [ID_W:0]   cand;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      cand = {1'b0, start} + (ID_W+1)'(i);
      if (cand >= PORTS_W) cand = cand - PORTS_W;
      if (!found && elig[cand[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_W-1:0];
      end
    end
    return pick;
  endfunction

  function automatic logic [PORTS-1:0] onehot(input logic [ID_W-1:0] idx);
    return PORTS'(1) << idx;
  endfunction

  assign eligible    = bus.req & AVAILABLE_PORTS;
  assign is_locked   = (state_q == LOCKED);
  assign accept_w    = is_locked & bus.req[id_q] & bus.out_ready;
  assign tail_accept = accept_w & bus.tail[id_q];
  assign next_ptr    = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);

  // Two searches: from the stored pointer for an idle output, and from the
  // post-tail pointer so the next packet can start with no bubble.
  assign pick_idle = rr_pick(eligible, ptr_q);
  assign pick_tail = rr_pick(eligible, next_ptr);

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.locked   = is_locked;
  assign bus.accept   = accept_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  // The pointer only moves on a tail transfer; a dropped req or low
  // out_ready while locked simply holds everything.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = LOCKED;
          grant_d = onehot(pick_idle);
          id_d    = pick_idle;
        end
      end
      LOCKED: begin
        if (tail_accept) begin
          ptr_d = next_ptr;
          if (|eligible) begin
            grant_d = onehot(pick_tail);
            id_d    = pick_tail;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter
// Scoreboard bench: each test queues stimulus vectors together with the
// outputs expected for them, then plays the queue and compares the DUT.
// Two instances: dut_a with every port available, dut_b with mask 5'b10110.
module tb_noc_output_arbiter;

  typedef struct packed {
    logic [4:0] grant;
    logic [2:0] grant_id;
    logic       locked;
    logic       accept;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       rdy;
    logic       chk;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] a_req = '0, a_tail = '0, b_req = '0, b_tail = '0;
  logic       a_rdy = 1'b0, b_rdy = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  stim_t stim_q[$];
  obs_t  exp_q[$];

  localparam obs_t IDLE_E = '0;

  always #5 clk = ~clk;

  noc_output_arbiter_if #(.PORTS(5)) bus_a ();
  noc_output_arbiter_if #(.PORTS(5)) bus_b ();

  assign bus_a.req       = a_req;
  assign bus_a.tail      = a_tail;
  assign bus_a.out_ready = a_rdy;
  assign bus_b.req       = b_req;
  assign bus_b.tail      = b_tail;
  assign bus_b.out_ready = b_rdy;

  noc_output_arbiter #(.PORTS(5), .AVAILABLE_PORTS(5'b11111)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  noc_output_arbiter #(.PORTS(5), .AVAILABLE_PORTS(5'b10110)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic obs_t lk(input int id, input logic acc);
    obs_t o;
    o.grant    = 5'b00001 << id;
    o.grant_id = 3'(id);
    o.locked   = 1'b1;
    o.accept   = acc;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("grant=%b id=%0d locked=%b accept=%b",
                     o.grant, o.grant_id, o.locked, o.accept);
  endfunction

  function automatic obs_t sample(input bit to_b);
    if (to_b) return {bus_b.grant, bus_b.grant_id, bus_b.locked, bus_b.accept};
    return {bus_a.grant, bus_a.grant_id, bus_a.locked, bus_a.accept};
  endfunction

  task automatic push(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                      input logic rd, input logic chk, input obs_t e);
    stim_t s;
    s.rst  = r;
    s.req  = rq;
    s.tail = tl;
    s.rdy  = rd;
    s.chk  = chk;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input stim_t s, input bit to_b);
    @(negedge clk);
    rst = s.rst;
    if (to_b) begin
      b_req = s.req; b_tail = s.tail; b_rdy = s.rdy;
      a_req = '0;    a_tail = '0;     a_rdy = 1'b0;
    end else begin
      a_req = s.req; a_tail = s.tail; a_rdy = s.rdy;
      b_req = '0;    b_tail = '0;     b_rdy = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t s; obs_t e, o; int n = 0;
    push(1, 5'b00000, 5'b00000, 1, 1, IDLE_E);
    push(1, 5'b11111, 5'b00000, 1, 1, IDLE_E);
    push(1, 5'b11111, 5'b11111, 1, 1, IDLE_E);
    push(0, 5'b00000, 5'b00000, 1, 1, IDLE_E);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      applyStimulus(s, 1'b0);
      o = sample(1'b0);
      if (s.chk) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL reset vec %0d: got %s want %s", n, fmt(o), fmt(e));
        end
      end
      n++;
    end
  endtask

  task automatic test_single();
    stim_t s; obs_t e, o; int n = 0;
    push(1, 5'b00000, 5'b00000, 1, 0, IDLE_E);
    push(0, 5'b00100, 5'b00000, 1, 1, IDLE_E);
    push(0, 5'b00100, 5'b00000, 1, 1, lk(2, 1));
    push(0, 5'b00100, 5'b00000, 1, 1, lk(2, 1));
    push(0, 5'b01100, 5'b00100, 1, 1, lk(2, 1));
    push(0, 5'b00000, 5'b00000, 1, 1, lk(3, 0));
    push(0, 5'b01000, 5'b01000, 1, 1, lk(3, 1));
    push(0, 5'b00000, 5'b00000, 1, 1, lk(3, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      applyStimulus(s, 1'b0);
      o = sample(1'b0);
      if (s.chk) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL single vec %0d: got %s want %s", n, fmt(o), fmt(e));
        end
      end
      n++;
    end
  endtask

  task automatic test_fairness();
    stim_t s; obs_t e, o; int n = 0;
    push(1, 5'b00000, 5'b00000, 1, 0, IDLE_E);
    push(0, 5'b11111, 5'b11111, 1, 1, IDLE_E);
    for (int k = 0; k < 6; k++) push(0, 5'b11111, 5'b11111, 1, 1, lk(k % 5, 1));
    push(0, 5'b00000, 5'b00000, 1, 1, lk(1, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      applyStimulus(s, 1'b0);
      o = sample(1'b0);
      if (s.chk) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL fairness vec %0d: got %s want %s", n, fmt(o), fmt(e));
        end
      end
      n++;
    end
  endtask

  task automatic test_packet_lock();
    stim_t s; obs_t e, o; int n = 0;
    push(1, 5'b00000, 5'b00000, 1, 0, IDLE_E);
    push(0, 5'b00010, 5'b00000, 1, 1, IDLE_E);
    push(0, 5'b00010, 5'b00000, 1, 1, lk(1, 1));
    push(0, 5'b00011, 5'b00001, 1, 1, lk(1, 1));
    push(0, 5'b00011, 5'b00000, 1, 1, lk(1, 1));
    push(0, 5'b00011, 5'b00010, 1, 1, lk(1, 1));
    push(0, 5'b00001, 5'b00000, 1, 1, lk(0, 1));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      applyStimulus(s, 1'b0);
      o = sample(1'b0);
      if (s.chk) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL packet_lock vec %0d: got %s want %s", n, fmt(o), fmt(e));
        end
      end
      n++;
    end
  endtask

  task automatic test_backpressure();
    stim_t s; obs_t e, o; int n = 0;
    push(1, 5'b00000, 5'b00000, 1, 0, IDLE_E);
    push(0, 5'b10000, 5'b00000, 1, 1, IDLE_E);
    push(0, 5'b10000, 5'b00000, 1, 1, lk(4, 1));
    push(0, 5'b10000, 5'b10000, 0, 1, lk(4, 0));
    push(0, 5'b10001, 5'b10000, 0, 1, lk(4, 0));
    push(0, 5'b10001, 5'b10000, 0, 1, lk(4, 0));
    push(0, 5'b00001, 5'b00000, 1, 1, lk(4, 0));
    push(0, 5'b10001, 5'b10000, 1, 1, lk(4, 1));
    push(0, 5'b00000, 5'b00000, 1, 1, lk(0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      applyStimulus(s, 1'b0);
      o = sample(1'b0);
      if (s.chk) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL backpressure vec %0d: got %s want %s", n, fmt(o), fmt(e));
        end
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_packet();
    stim_t s; obs_t e, o; int n = 0;
    push(1, 5'b00000, 5'b00000, 1, 0, IDLE_E);
    push(0, 5'b01000, 5'b00000, 1, 1, IDLE_E);
    for (int k = 0; k < 4; k++) push(0, 5'b01000, 5'b00000, 1, 1, lk(3, 1));
    push(1, 5'b01000, 5'b00000, 1, 1, lk(3, 1));
    push(0, 5'b01000, 5'b00000, 1, 1, IDLE_E);
    push(0, 5'b01001, 5'b01000, 1, 1, lk(3, 1));
    push(0, 5'b00000, 5'b00000, 1, 1, lk(0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      applyStimulus(s, 1'b0);
      o = sample(1'b0);
      if (s.chk) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL reset_mid_packet vec %0d: got %s want %s", n, fmt(o), fmt(e));
        end
      end
      n++;
    end
  endtask

  task automatic test_masking();
    stim_t s; obs_t e, o; int n = 0;
    push(1, 5'b00000, 5'b00000, 1, 0, IDLE_E);
    push(0, 5'b00100, 5'b00100, 1, 1, IDLE_E);
    push(0, 5'b11111, 5'b11111, 1, 1, lk(2, 1));
    push(0, 5'b11111, 5'b11111, 1, 1, lk(4, 1));
    push(0, 5'b11111, 5'b11111, 1, 1, lk(1, 1));
    push(0, 5'b11111, 5'b11111, 1, 1, lk(2, 1));
    push(0, 5'b11111, 5'b11111, 1, 1, lk(4, 1));
    push(0, 5'b00001, 5'b00001, 1, 1, lk(1, 0));
    push(0, 5'b00011, 5'b00011, 1, 1, lk(1, 1));
    push(0, 5'b01001, 5'b00000, 1, 1, lk(1, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      applyStimulus(s, 1'b1);
      o = sample(1'b1);
      if (s.chk) begin
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL masking vec %0d: got %s want %s", n, fmt(o), fmt(e));
        end
      end
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b1;
    end
    $display("[TB] test_reset");            test_reset();
    $display("[TB] test_single");           test_single();
    $display("[TB] test_fairness");         test_fairness();
    $display("[TB] test_packet_lock");      test_packet_lock();
    $display("[TB] test_backpressure");     test_backpressure();
    $display("[TB] test_reset_mid_packet"); test_reset_mid_packet();
    $display("[TB] test_masking");          test_masking();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
